// File: rtl/mac_element_pkg.sv
// rtl/mac_element_pkg.sv - shared types, direction indices and operand pairing for mac_element
package mac_element_pkg;

  typedef enum logic [1:0] {
    MODE_MUL  = 2'd0,
    MODE_ACC  = 2'd1,
    MODE_PASS = 2'd2
  } mode_e;

  localparam int NUM_DIRS  = 4;
  localparam int DIR_DOWN  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_LEFT  = 3;

  // Output direction -> (a, b) input directions feeding its multiplier.
  function automatic int pair_a(input int dir);
    case (dir)
      DIR_DOWN:  return DIR_LEFT;
      DIR_RIGHT: return DIR_UP;
      DIR_UP:    return DIR_RIGHT;
      default:   return DIR_DOWN;
    endcase
  endfunction

  function automatic int pair_b(input int dir);
    case (dir)
      DIR_DOWN:  return DIR_UP;
      DIR_RIGHT: return DIR_RIGHT;
      DIR_UP:    return DIR_DOWN;
      default:   return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/mac_element_if.sv
// rtl/mac_element_if.sv - directional data, control and LSB side-chain bundle of one tile
interface mac_element_if #(
  parameter int DATA_W = 64,
  parameter int LSB_W  = 8
);
  logic [DATA_W-1:0] io_ins_down;
  logic [DATA_W-1:0] io_ins_right;
  logic [DATA_W-1:0] io_ins_up;
  logic [DATA_W-1:0] io_ins_left;
  logic [3:0]        io_ins_valid;
  logic [1:0]        io_mode;
  logic              io_acc_clear;
  logic [DATA_W-1:0] io_outs_down;
  logic [DATA_W-1:0] io_outs_right;
  logic [DATA_W-1:0] io_outs_up;
  logic [DATA_W-1:0] io_outs_left;
  logic [3:0]        io_outs_valid;
  logic [LSB_W-1:0]  io_lsbIns;
  logic [LSB_W-1:0]  io_lsbOuts;

  modport master (
    output io_ins_down, io_ins_right, io_ins_up, io_ins_left, io_ins_valid,
    output io_mode, io_acc_clear, io_lsbIns,
    input  io_outs_down, io_outs_right, io_outs_up, io_outs_left, io_outs_valid,
    input  io_lsbOuts
  );

  modport slave (
    input  io_ins_down, io_ins_right, io_ins_up, io_ins_left, io_ins_valid,
    input  io_mode, io_acc_clear, io_lsbIns,
    output io_outs_down, io_outs_right, io_outs_up, io_outs_left, io_outs_valid,
    output io_lsbOuts
  );
endinterface

// File: rtl/mac_multiplier.sv
// rtl/mac_multiplier.sv - unsigned pipelined multiplier, product only
module mac_multiplier #(
  parameter int OPERAND_W = 32,
  parameter int LATENCY   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [OPERAND_W-1:0]   a,
  input  logic [OPERAND_W-1:0]   b,
  output logic [2*OPERAND_W-1:0] product
);

  logic [2*OPERAND_W-1:0]              full;
  logic [LATENCY-1:0][2*OPERAND_W-1:0] stage;

  assign full    = {{OPERAND_W{1'b0}}, a} * {{OPERAND_W{1'b0}}, b};
  assign product = stage[LATENCY-1];

  if (LATENCY > 1) begin : g_multi
    always_ff @(posedge clock) begin
      if (reset) stage <= '0;
      else       stage <= {stage[LATENCY-2:0], full};
    end
  end else begin : g_single
    always_ff @(posedge clock) begin
      if (reset) stage <= '0;
      else       stage <= full;
    end
  end

endmodule

// File: rtl/mac_element.sv
// rtl/mac_element.sv - four-direction systolic tile: MUL / ACC / PASS per channel, LSB side-chain
module mac_element
  import mac_element_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int OPERAND_W    = 32,
  parameter int RESULT_W     = 16,
  parameter int MULT_LATENCY = 2,
  parameter int LSB_W        = 8,
  parameter int LSB_REG_IDX  = 3
) (
  input  logic         clock,
  input  logic         reset,
  mac_element_if.slave bus
);

  // S0 at index 0, multiplier stages up to index MULT_LATENCY, product register last.
  localparam int PIPE_D = MULT_LATENCY + 2;

  logic [NUM_DIRS-1:0][DATA_W-1:0]   ins;
  logic [NUM_DIRS-1:0][RESULT_W-1:0] res_all;
  logic [NUM_DIRS-1:0]               vld_all;
  logic [PIPE_D-1:0][1:0]            mode_sr;
  logic                              lsb_q;
  logic                              unused_bits;

  assign ins[DIR_DOWN]  = bus.io_ins_down;
  assign ins[DIR_RIGHT] = bus.io_ins_right;
  assign ins[DIR_UP]    = bus.io_ins_up;
  assign ins[DIR_LEFT]  = bus.io_ins_left;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_sr <= '0;
      lsb_q   <= 1'b0;
    end else begin
      mode_sr <= {mode_sr[PIPE_D-2:0], bus.io_mode};
      lsb_q   <= bus.io_lsbIns[LSB_REG_IDX+1];
    end
  end

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_dir
    localparam int A = pair_a(g);
    localparam int B = pair_b(g);

    logic [OPERAND_W-1:0]             op_a;
    logic [OPERAND_W-1:0]             op_b;
    logic [2*OPERAND_W-1:0]           product;
    logic [PIPE_D-1:0]                vld_sr;
    logic [PIPE_D-1:0][RESULT_W-1:0]  pass_sr;
    logic [RESULT_W-1:0]              prod_q;
    logic [RESULT_W-1:0]              acc;
    logic [RESULT_W-1:0]              acc_sum;
    logic [RESULT_W-1:0]              res;
    logic                             res_vld;
    logic                             unused_prod;

    mac_multiplier #(
      .OPERAND_W (OPERAND_W),
      .LATENCY   (MULT_LATENCY)
    ) u_mult (
      .clock   (clock),
      .reset   (reset),
      .a       (op_a),
      .b       (op_b),
      .product (product)
    );

    // Clear takes effect before the add when a valid ACC slot coincides with it.
    assign acc_sum = (bus.io_acc_clear ? {RESULT_W{1'b0}} : acc) + prod_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        op_a    <= '0;
        op_b    <= '0;
        vld_sr  <= '0;
        pass_sr <= '0;
        prod_q  <= '0;
        acc     <= '0;
        res     <= '0;
        res_vld <= 1'b0;
      end else begin
        op_a    <= ins[A][OPERAND_W-1:0];
        op_b    <= ins[B][OPERAND_W-1:0];
        vld_sr  <= {vld_sr[PIPE_D-2:0], bus.io_ins_valid[A] & bus.io_ins_valid[B]};
        pass_sr <= {pass_sr[PIPE_D-2:0], ins[A][RESULT_W-1:0]};
        prod_q  <= product[RESULT_W-1:0];
        res_vld <= vld_sr[PIPE_D-1];
        if (bus.io_acc_clear) acc <= '0;
        if (vld_sr[PIPE_D-1]) begin
          case (mode_sr[PIPE_D-1])
            MODE_ACC: begin
              acc <= acc_sum;
              res <= acc_sum;
            end
            MODE_PASS: res <= pass_sr[PIPE_D-1];
            default:   res <= prod_q;
          endcase
        end
      end
    end

    assign unused_prod = ^product;
    assign res_all[g]  = res;
    assign vld_all[g]  = res_vld;
  end

  assign bus.io_outs_down  = DATA_W'(res_all[DIR_DOWN]);
  assign bus.io_outs_right = DATA_W'(res_all[DIR_RIGHT]);
  assign bus.io_outs_up    = DATA_W'(res_all[DIR_UP]);
  assign bus.io_outs_left  = DATA_W'(res_all[DIR_LEFT]);
  assign bus.io_outs_valid = vld_all;

  for (genvar i = 0; i < LSB_W - 1; i++) begin : g_lsb
    if (i == LSB_REG_IDX) begin : g_reg
      assign bus.io_lsbOuts[i] = lsb_q;
    end else begin : g_wire
      assign bus.io_lsbOuts[i] = bus.io_lsbIns[i+1];
    end
  end
  assign bus.io_lsbOuts[LSB_W-1] = res_all[DIR_LEFT][0];

  assign unused_bits = ^{ins, bus.io_lsbIns[0]};

endmodule

// File: tb/tb_mac_element.sv
// tb/tb_mac_element.sv - directed self-checking bench for mac_element
module tb_mac_element;

  logic clock = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  mac_element_if #(.DATA_W(64), .LSB_W(8)) bus ();

  mac_element #(
    .DATA_W       (64),
    .OPERAND_W    (32),
    .RESULT_W     (16),
    .MULT_LATENCY (2),
    .LSB_W        (8),
    .LSB_REG_IDX  (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [63:0] d, r, u, l, input logic [3:0] v);
    bus.io_ins_down  = d;
    bus.io_ins_right = r;
    bus.io_ins_up    = u;
    bus.io_ins_left  = l;
    bus.io_ins_valid = v;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(64'd0, 64'd0, 64'd0, 64'd0, 4'h0);
    bus.io_mode      = 2'd0;
    bus.io_acc_clear = 1'b0;
    bus.io_lsbIns    = 8'h00;
    tick(2);
    tests_run++;
    if ({bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down} !== 256'd0) begin
      tests_failed++;
      $display("FAIL reset_outs got %h exp 0", {bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down});
    end
    tests_run++;
    if (bus.io_outs_valid !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_valid got %b exp 0000", bus.io_outs_valid);
    end
    tests_run++;
    if (bus.io_lsbOuts !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_lsb got %b exp 00000000", bus.io_lsbOuts);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_mul_basic;
    bus.io_mode = 2'd0;
    drive(64'd3, 64'd7, 64'd11, 64'd5, 4'hF);
    tick(1);
    bus.io_ins_valid = 4'h0;
    tick(3);
    tests_run++;
    if (bus.io_outs_valid !== 4'h0) begin
      tests_failed++;
      $display("FAIL mul_early_valid got %b exp 0000", bus.io_outs_valid);
    end
    tick(1);
    tests_run++;
    if ({bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down} !==
        {64'd15, 64'd21, 64'd77, 64'd55}) begin
      tests_failed++;
      $display("FAIL mul_basic got %h exp l=15 u=21 r=77 d=55", {bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down});
    end
    tests_run++;
    if (bus.io_outs_valid !== 4'hF) begin
      tests_failed++;
      $display("FAIL mul_valid got %b exp 1111", bus.io_outs_valid);
    end
    tick(1);
    tests_run++;
    if (bus.io_outs_valid !== 4'h0 || bus.io_outs_left !== 64'd15) begin
      tests_failed++;
      $display("FAIL mul_hold got valid %b left %h exp 0000 / f", bus.io_outs_valid, bus.io_outs_left);
    end
  endtask

  task automatic test_lsb;
    bus.io_lsbIns = 8'b0001_0000;
    #1;
    tests_run++;
    if (bus.io_lsbOuts !== 8'b1000_0000) begin
      tests_failed++;
      $display("FAIL lsb_comb0 got %b exp 10000000", bus.io_lsbOuts);
    end
    tick(1);
    tests_run++;
    if (bus.io_lsbOuts !== 8'b1000_1000) begin
      tests_failed++;
      $display("FAIL lsb_reg_rise got %b exp 10001000", bus.io_lsbOuts);
    end
    bus.io_lsbIns = 8'b0000_1110;
    #1;
    tests_run++;
    if (bus.io_lsbOuts !== 8'b1000_1111) begin
      tests_failed++;
      $display("FAIL lsb_comb1 got %b exp 10001111", bus.io_lsbOuts);
    end
    tick(1);
    tests_run++;
    if (bus.io_lsbOuts !== 8'b1000_0111) begin
      tests_failed++;
      $display("FAIL lsb_reg_fall got %b exp 10000111", bus.io_lsbOuts);
    end
    bus.io_lsbIns = 8'h00;
  endtask

  task automatic test_truncate;
    bus.io_mode = 2'd0;
    drive(64'h1_0003, 64'd0, 64'd0, 64'd2, 4'hF);
    tick(1);
    bus.io_ins_valid = 4'h0;
    tick(4);
    tests_run++;
    if ({bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down} !==
        {64'h6, 64'd0, 64'd0, 64'd0}) begin
      tests_failed++;
      $display("FAIL mul_truncate got %h exp l=6 others 0", {bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down});
    end
  endtask

  task automatic test_acc;
    logic [15:0] exp_left [3];
    exp_left[0] = 16'hFFFF;
    exp_left[1] = 16'hFFFE;
    exp_left[2] = 16'hFFFD;
    bus.io_acc_clear = 1'b1;
    tick(1);
    bus.io_acc_clear = 1'b0;
    tests_run++;
    if (bus.io_outs_left !== 64'h6 || bus.io_outs_valid !== 4'h0) begin
      tests_failed++;
      $display("FAIL clear_alone got left %h valid %b exp 6 / 0000", bus.io_outs_left, bus.io_outs_valid);
    end
    bus.io_mode = 2'd1;
    drive(64'hFFFF, 64'd0, 64'd1, 64'd1, 4'hF);
    tick(3);
    bus.io_ins_valid = 4'h0;
    bus.io_mode      = 2'd0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      tests_run++;
      if (bus.io_outs_left !== {48'd0, exp_left[i]} || bus.io_outs_down !== 64'(i + 1)) begin
        tests_failed++;
        $display("FAIL acc_wrap[%0d] got left %h down %h exp %h / %0d", i, bus.io_outs_left, bus.io_outs_down, exp_left[i], i + 1);
      end
    end
    bus.io_mode = 2'd1;
    drive(64'd2, 64'd0, 64'd1, 64'd2, 4'hF);
    tick(1);
    bus.io_ins_valid = 4'h0;
    bus.io_mode      = 2'd0;
    tick(3);
    bus.io_acc_clear = 1'b1;
    tick(1);
    bus.io_acc_clear = 1'b0;
    tests_run++;
    if ({bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down} !==
        {64'd4, 64'd0, 64'd0, 64'd2} || bus.io_outs_valid !== 4'hF) begin
      tests_failed++;
      $display("FAIL acc_clear_add got %h valid %b exp l=4 u=0 r=0 d=2 / 1111", {bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down}, bus.io_outs_valid);
    end
  endtask

  task automatic test_mask_pass;
    bus.io_mode = 2'd2;
    drive(64'h55, 64'hFFFF_1234, 64'hAB, 64'h77, 4'b0111);
    tick(1);
    bus.io_ins_valid = 4'h0;
    bus.io_mode      = 2'd0;
    tick(4);
    tests_run++;
    if ({bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down} !==
        {64'd4, 64'h1234, 64'hAB, 64'd2}) begin
      tests_failed++;
      $display("FAIL mask_pass got %h exp l=4 u=1234 r=ab d=2", {bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down});
    end
    tests_run++;
    if (bus.io_outs_valid !== 4'b0110) begin
      tests_failed++;
      $display("FAIL mask_valid got %b exp 0110", bus.io_outs_valid);
    end
  endtask

  task automatic test_reset_midstream;
    bus.io_mode = 2'd0;
    drive(64'd1, 64'd1, 64'd1, 64'd1, 4'hF);
    tick(3);
    bus.io_ins_valid = 4'h0;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tests_run++;
    if ({bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down} !== 256'd0 ||
        bus.io_outs_valid !== 4'h0) begin
      tests_failed++;
      $display("FAIL midreset_clear got %h valid %b exp 0 / 0000", {bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down}, bus.io_outs_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      tests_run++;
      if (bus.io_outs_valid !== 4'h0) begin
        tests_failed++;
        $display("FAIL midreset_stale[%0d] got %b exp 0000", i, bus.io_outs_valid);
      end
    end
    drive(64'd2, 64'd3, 64'd4, 64'd5, 4'hF);
    tick(1);
    bus.io_ins_valid = 4'h0;
    tick(3);
    tests_run++;
    if (bus.io_outs_valid !== 4'h0) begin
      tests_failed++;
      $display("FAIL postreset_early got %b exp 0000", bus.io_outs_valid);
    end
    tick(1);
    tests_run++;
    if ({bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down} !==
        {64'd10, 64'd6, 64'd12, 64'd20} || bus.io_outs_valid !== 4'hF) begin
      tests_failed++;
      $display("FAIL postreset_first got %h valid %b exp l=10 u=6 r=12 d=20 / 1111", {bus.io_outs_left, bus.io_outs_up, bus.io_outs_right, bus.io_outs_down}, bus.io_outs_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_lsb();
    test_truncate();
    test_acc();
    test_mask_pass();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mac_element.md
# mac_element

Parametrised successor to the mock-array processing element: a four-direction systolic tile with per-direction valid qualification and a selectable multiply / accumulate / pass-through mode. Each output direction is driven by a pipelined product of two registered directional inputs. The LSB side-chain is carried through for array-level timing tests. Tiles abut in the mock-array grid; neighbours connect `io_outs_*` to `io_ins_*`.

## Interface
- `DATA_W`, 64: width of every directional bus.
- `OPERAND_W`, 32: low bits of each input used as a multiplier operand; `OPERAND_W <= DATA_W`.
- `RESULT_W`, 16: low product / accumulator bits driven out, zero-extended to `DATA_W`; `RESULT_W <= 2*OPERAND_W`.
- `MULT_LATENCY`, 2: multiplier pipeline stages, >= 1.
- `LSB_W`, 8: LSB side-chain width, >= 2.
- `LSB_REG_IDX`, 3: chain position that is registered; `LSB_REG_IDX < LSB_W-1`.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `io_ins_down`, `io_ins_right`, `io_ins_up`, `io_ins_left` in `DATA_W`: directional data.
- `io_ins_valid` in 4: per-input valid, bit order [down, right, up, left] = [0..3].
- `io_mode` in 2: 0 = MUL, 1 = ACC, 2 = PASS, 3 = reserved (treated as MUL).
- `io_acc_clear` in 1: clears all accumulators.
- `io_outs_down`, `io_outs_right`, `io_outs_up`, `io_outs_left` out `DATA_W`: results.
- `io_outs_valid` out 4: per-output valid, same bit order.
- `io_lsbIns` in `LSB_W`: side-chain in; bit 0 unused.
- `io_lsbOuts` out `LSB_W`: side-chain out.

## Operation
- Fixed operand pairing as (a, b): left = (down, left); up = (right, down); right = (up, right); down = (left, up).
- Stage S0: all four input buses are registered, together with the per-channel valid and `io_mode`. Channel valid = AND of its two input valids.
  - Registers load every cycle; valid only qualifies the result.
- S1..S`MULT_LATENCY`: unsigned product `a[OPERAND_W-1:0] * b[OPERAND_W-1:0]`, full `2*OPERAND_W` width. Valid and mode ride alongside in shift registers.
- Output stage, per channel, when its pipelined valid is 1:
  - MUL: out = product[`RESULT_W`-1:0].
  - ACC: acc = acc + product[`RESULT_W`-1:0], modulo 2^`RESULT_W` (wrap, no saturation). Out = the new acc.
  - PASS: out = a[`RESULT_W`-1:0], delayed to the same latency. The multiplier is still clocked.
- Invalid slots: out and acc hold their values; `io_outs_valid` bit = 0.
- `io_acc_clear` is sampled at the output stage. A valid ACC slot in the same cycle yields acc = product (clear, then add). Otherwise acc = 0.
  - Outputs are unchanged by a clear alone.
- A mode change applies per slot. In-flight slots finish in the mode they captured.
- LSB chain:
  - `io_lsbOuts[i] = io_lsbIns[i+1]` combinationally, for i < `LSB_W-1`, i != `LSB_REG_IDX`.
  - `io_lsbOuts[LSB_REG_IDX]` = `io_lsbIns[LSB_REG_IDX+1]` delayed one cycle.
  - `io_lsbOuts[LSB_W-1] = io_outs_left[0]`.

## Timing
- Latency from input to result is `MULT_LATENCY+2` cycles (default 4). Inputs are sampled at edge N; outputs and valid update at edge N+`MULT_LATENCY`+2.
- Throughput is one result per channel per cycle. There is no backpressure; the receiver must accept every valid result.
- Reset: every register clears in the same cycle, including S0, the multiplier stages, valids, accumulators, outputs and the LSB register.
  - After reset: `io_outs_*` = 0, `io_outs_valid` = 0, `io_lsbOuts[LSB_REG_IDX]` = 0.
- Reset mid-stream discards all in-flight slots. No valid pulse may appear until the first post-reset valid input reaches the output, `MULT_LATENCY+2` cycles after it is sampled.
- Upper bits of each output, [`DATA_W`-1:`RESULT_W`], are always 0.

## Structure
- Shared package `mac_element_pkg`:
  - mode enum (`MODE_MUL`, `MODE_ACC`, `MODE_PASS`);
  - direction index constants (`DIR_DOWN` .. `DIR_LEFT`);
  - the operand-pairing table.
- One sub-module, `mac_multiplier`:
  - parameters `OPERAND_W` and `LATENCY`;
  - unsigned, with synchronous reset;
  - it carries only the product, not valid or mode.
- Four instances of `mac_multiplier`, generated over the direction index.

## Test plan
- Reset, then all valids 1, MUL mode; down=3, left=5, right=7, up=11. At cycle 4: left=15, up=21, right=77, down=55; `io_outs_valid` = 4'b1111.
- MUL with down=0x1_0003, left=0x2 → out_left=0x0006. The upper product bits are truncated and out bits [63:16] are 0.
- ACC, down=0xFFFF, left=1 for 3 consecutive valid cycles → out_left = 0xFFFF, 0xFFFE, 0xFFFD (wrap). Then `io_acc_clear` together with a valid product of 4 → out_left=4.
- `io_ins_valid`=4'b0111 (left invalid) → left and down outputs hold with valid bit 0; up and right update. PASS with right=0x1234 → out_up=0x1234 at cycle 4.
- Assert `reset` 2 cycles after a valid burst → outputs and valid are 0 the next cycle, and no stale valid pulse follows.
- LSB chain: drive `io_lsbIns`=8'b0001_0000 → `io_lsbOuts[3]` rises 1 cycle later; `io_lsbOuts[2:0]` follow `io_lsbIns[3:1]` in the same cycle.
